// File: rtl/ascon_pack.sv
// Shared ASCON state types for the permutation datapath.
package ascon_pack;

    localparam int unsigned ROW_W = 64;

    // Row bit (ROW_W-1-j) holds column j, so the flat 320-bit image matches a logic[0:63] row view.
    typedef logic [ROW_W-1:0] type_row;

    // x0 occupies the top 64 bits of the flat image, x4 the bottom 64.
    typedef struct packed {
        type_row x0;
        type_row x1;
        type_row x2;
        type_row x3;
        type_row x4;
    } type_state;

endpackage

// File: rtl/inv_sbox_layer.sv
// Iterative ASCON inverse substitution layer: COLS_PER_CYCLE bit-sliced columns per clock.
module inv_sbox_layer
    import ascon_pack::*;
#(
    parameter int unsigned COLS_PER_CYCLE = 8
) (
    input  logic      clock_i,
    input  logic      resetb_i,
    input  logic      start_i,
    input  type_state state_i,
    output type_state state_o,
    output logic      busy_o,
    output logic      done_o
);

    localparam int unsigned NUM_COLS   = 64;
    localparam int unsigned NUM_GROUPS = NUM_COLS / COLS_PER_CYCLE;
    localparam int unsigned CNT_W      = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;
    localparam logic [CNT_W-1:0] LAST_GROUP = CNT_W'(NUM_GROUPS - 1);

    // Only power-of-two group sizes divide the 64 columns evenly.
    if (COLS_PER_CYCLE != 1  && COLS_PER_CYCLE != 2  && COLS_PER_CYCLE != 4 &&
        COLS_PER_CYCLE != 8  && COLS_PER_CYCLE != 16 && COLS_PER_CYCLE != 32 &&
        COLS_PER_CYCLE != 64) begin : g_bad_cols
        $error("inv_sbox_layer: COLS_PER_CYCLE=%0d must be one of 1,2,4,8,16,32,64",
               COLS_PER_CYCLE);
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } fsm_e;

    fsm_e             fsm_q, fsm_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    type_state        st_q, st_d;
    type_state        sub_state;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // ASCON inverse S-box; bit 4 of the index/result is row x0.
    function automatic logic [4:0] inv_sbox(input logic [4:0] v);
        logic [4:0] r;
        case (v)
            5'h00: r = 5'h14;  5'h01: r = 5'h1A;  5'h02: r = 5'h07;  5'h03: r = 5'h0D;
            5'h04: r = 5'h00;  5'h05: r = 5'h09;  5'h06: r = 5'h0E;  5'h07: r = 5'h12;
            5'h08: r = 5'h0A;  5'h09: r = 5'h06;  5'h0A: r = 5'h1D;  5'h0B: r = 5'h01;
            5'h0C: r = 5'h19;  5'h0D: r = 5'h15;  5'h0E: r = 5'h13;  5'h0F: r = 5'h1E;
            5'h10: r = 5'h18;  5'h11: r = 5'h16;  5'h12: r = 5'h0B;  5'h13: r = 5'h11;
            5'h14: r = 5'h03;  5'h15: r = 5'h05;  5'h16: r = 5'h1C;  5'h17: r = 5'h1F;
            5'h18: r = 5'h17;  5'h19: r = 5'h1B;  5'h1A: r = 5'h04;  5'h1B: r = 5'h08;
            5'h1C: r = 5'h0F;  5'h1D: r = 5'h0C;  5'h1E: r = 5'h10;  default: r = 5'h02;
        endcase
        return r;
    endfunction

    // Working register with the current group of columns substituted in place.
    always_comb begin
        logic [5:0] col;
        logic [5:0] pos;
        logic [4:0] img;
        sub_state = st_q;
        col       = '0;
        pos       = '0;
        img       = '0;
        for (int unsigned g = 0; g < COLS_PER_CYCLE; g++) begin
            col = 6'(32'(cnt_q) * COLS_PER_CYCLE + g);
            pos = 6'(NUM_COLS - 1) - col;
            img = inv_sbox({st_q.x0[pos], st_q.x1[pos], st_q.x2[pos],
                            st_q.x3[pos], st_q.x4[pos]});
            sub_state.x0[pos] = img[4];
            sub_state.x1[pos] = img[3];
            sub_state.x2[pos] = img[2];
            sub_state.x3[pos] = img[1];
            sub_state.x4[pos] = img[0];
        end
    end

    // Next-state, counter, datapath and registered-output decode.
    always_comb begin
        fsm_d  = fsm_q;
        cnt_d  = cnt_q;
        st_d   = st_q;
        busy_d = 1'b0;
        done_d = 1'b0;
        case (fsm_q)
            S_IDLE: begin
                if (start_i) begin
                    st_d   = state_i;
                    cnt_d  = '0;
                    fsm_d  = S_RUN;
                    busy_d = 1'b1;
                end
            end
            S_RUN: begin
                st_d = sub_state;
                if (cnt_q == LAST_GROUP) begin
                    cnt_d  = '0;
                    fsm_d  = S_DONE;
                    done_d = 1'b1;
                end else begin
                    cnt_d  = cnt_q + CNT_W'(1);
                    busy_d = 1'b1;
                end
            end
            S_DONE: begin
                fsm_d = S_IDLE;
            end
            default: begin
                fsm_d = S_IDLE;
            end
        endcase
    end

    // State register; reset clears the working state so a partial pass is discarded.
    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            fsm_q  <= S_IDLE;
            cnt_q  <= '0;
            st_q   <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            fsm_q  <= fsm_d;
            cnt_q  <= cnt_d;
            st_q   <= st_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign state_o = st_q;
    assign busy_o  = busy_q;
    assign done_o  = done_q;

endmodule

// File: tb/tb_inv_sbox_layer.sv
// Scoreboard bench for inv_sbox_layer at C=1, C=8 and C=64.
`timescale 1ns/1ps
module tb_inv_sbox_layer;
    import ascon_pack::*;

    localparam int NDUT = 3;
    localparam int unsigned CFG_C [NDUT] = '{1, 8, 64};

    typedef struct packed {
        type_state   din;
        type_state   res;
        logic [31:0] iss;
    } exp_t;

    logic      clk = 1'b0;
    logic      rst_n = 1'b0;
    logic      start_v [NDUT];
    type_state din_v   [NDUT];
    type_state dout_v  [NDUT];
    logic      busy_v  [NDUT];
    logic      done_v  [NDUT];
    logic      prev_done [NDUT];
    type_state last_res  [NDUT];
    exp_t      exp_q [NDUT][$];

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    int unsigned cyc   = 0;

    // Forward ASCON S-box; the inverse is derived from it by search.
    logic [4:0] fwd_tab [32] = '{5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
                                 5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
                                 5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
                                 5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};
    logic [4:0] inv_tab [32];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        inv_sbox_layer #(.COLS_PER_CYCLE(CFG_C[g])) u_dut (
            .clock_i  (clk),
            .resetb_i (rst_n),
            .start_i  (start_v[g]),
            .state_i  (din_v[g]),
            .state_o  (dout_v[g]),
            .busy_o   (busy_v[g]),
            .done_o   (done_v[g])
        );
    end

    // Column j of row r lives at flat bit 319 - 64*r - j; x0 is the column MSB.
    function automatic logic [4:0] get_col(type_state s, int j);
        logic [319:0] f;
        logic [4:0]   c;
        f = s;
        for (int r = 0; r < 5; r++) c[4-r] = f[319 - 64*r - j];
        return c;
    endfunction

    function automatic type_state set_col(type_state s, int j, logic [4:0] c);
        logic [319:0] f;
        f = s;
        for (int r = 0; r < 5; r++) f[319 - 64*r - j] = c[4-r];
        return f;
    endfunction

    function automatic type_state model_inv(type_state s);
        type_state o;
        o = s;
        for (int j = 0; j < 64; j++) o = set_col(o, j, inv_tab[get_col(s, j)]);
        return o;
    endfunction

    function automatic type_state model_fwd(type_state s);
        type_state o;
        o = s;
        for (int j = 0; j < 64; j++) o = set_col(o, j, fwd_tab[get_col(s, j)]);
        return o;
    endfunction

    function automatic type_state fill(logic [4:0] v);
        type_state o;
        o = '0;
        for (int j = 0; j < 64; j++) o = set_col(o, j, v);
        return o;
    endfunction

    function automatic type_state rand_state();
        logic [319:0] f;
        for (int w = 0; w < 10; w++) f[32*w +: 32] = $urandom();
        return f;
    endfunction

    task automatic check(string name, logic [319:0] act, logic [319:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, need %0h", name, act, req);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding pass of that instance.
    always @(negedge clk) begin
        exp_t e;
        for (int i = 0; i < NDUT; i++) begin
            if (done_v[i]) begin
                check("done_single_cycle", 320'(prev_done[i]), 320'(0));
                if (exp_q[i].size() == 0) begin
                    check("spurious_done", 320'(done_v[i]), 320'(0));
                end else begin
                    e = exp_q[i].pop_front();
                    check("state_o", dout_v[i], e.res);
                    check("round_trip", model_fwd(dout_v[i]), e.din);
                    check("latency", 320'(cyc - e.iss + 1), 320'(64 / CFG_C[i] + 1));
                    check("busy_at_done", 320'(busy_v[i]), 320'(0));
                    last_res[i] = dout_v[i];
                end
            end
            prev_done[i] = done_v[i];
        end
    end

    task automatic issue(int i, type_state d, type_state r);
        exp_t e;
        @(negedge clk);
        din_v[i]   = d;
        start_v[i] = 1'b1;
        e.din = d;
        e.res = r;
        e.iss = cyc + 1;
        exp_q[i].push_back(e);
        @(negedge clk);
        start_v[i] = 1'b0;
    endtask

    task automatic drain(int i, int budget);
        int k;
        k = 0;
        while (exp_q[i].size() != 0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (exp_q[i].size() != 0) begin
            check("drain_timeout", 320'(exp_q[i].size()), 320'(0));
            exp_q[i].delete();
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got no completion, need $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        type_state d;
        type_state hold_ref;
        int        nrand [NDUT];
        exp_t      e;

        nrand = '{30, 200, 1000};
        for (int v = 0; v < 32; v++) inv_tab[fwd_tab[v]] = 5'(v);
        for (int i = 0; i < NDUT; i++) begin
            start_v[i]   = 1'b0;
            din_v[i]     = '0;
            prev_done[i] = 1'b0;
            last_res[i]  = '0;
        end

        // Reset values.
        #23;
        for (int i = 0; i < NDUT; i++) begin
            check("rst_state_o", dout_v[i], '0);
            check("rst_busy", 320'(busy_v[i]), 320'(0));
            check("rst_done", 320'(done_v[i]), 320'(0));
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Single non-zero column at C=8.
        d = set_col('0, 0, 5'h17);
        issue(1, d, model_inv(d));
        drain(1, 40);
        check("col0_image", 320'(get_col(dout_v[1], 0)), 320'(5'h1F));
        check("col5_image", 320'(get_col(dout_v[1], 5)), 320'(5'h14));

        // Exhaustive round trip on every configuration.
        for (int i = 0; i < NDUT; i++) begin
            for (int v = 0; v < 32; v++) begin
                issue(i, fill(fwd_tab[v]), fill(5'(v)));
                drain(i, 200);
            end
        end

        // Random states.
        for (int i = 0; i < NDUT; i++) begin
            for (int n = 0; n < nrand[i]; n++) begin
                d = rand_state();
                issue(i, d, model_inv(d));
                drain(i, 200);
            end
        end

        // start held high for 40 cycles at C=8: accepted at 0, 10, 20, 30.
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            d          = rand_state();
            din_v[1]   = d;
            start_v[1] = 1'b1;
            if (k % 10 == 0) begin
                e.din = d;
                e.res = model_inv(d);
                e.iss = cyc + 1;
                exp_q[1].push_back(e);
            end
        end
        @(negedge clk);
        start_v[1] = 1'b0;
        drain(1, 40);

        // Result holds while state_i changes without start.
        hold_ref = last_res[1];
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            din_v[1] = rand_state();
            check("hold_state_o", dout_v[1], hold_ref);
        end

        // Reset in the middle of a C=8 pass.
        @(negedge clk);
        din_v[1]   = rand_state();
        start_v[1] = 1'b1;
        @(negedge clk);
        start_v[1] = 1'b0;
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("abort_state_o", dout_v[1], '0);
        check("abort_busy", 320'(busy_v[1]), 320'(0));
        check("abort_done", 320'(done_v[1]), 320'(0));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        d = rand_state();
        issue(1, d, model_inv(d));
        drain(1, 40);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
